// File: rtl/router_pkg.sv
// Shared constants and types for the router output-port logic.
// Port indices follow the mesh orientation used by route computation.
package router_pkg;

  localparam int DEF_N_IN   = 5;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_FLIT_W = 32;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/router_out_port_arbiter_picker.sv
// Round-robin pick: first requester at or after the pointer,
// wrapping modulo N.
module rr_priority_picker
  import router_pkg::*;
#(
  parameter int N  = DEF_N_IN,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int   j;
  logic found;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/router_out_port_arbiter.sv
// Output-port arbiter: round-robin grant held for a whole packet,
// muxing the granted input's flit stream onto the output link.
module router_out_port_arbiter
  import router_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int FLIT_W  = DEF_FLIT_W,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          in_req,
  input  logic [N_IN*ADDR_W-1:0]   in_src_addr,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN-1:0]          in_last,
  input  logic [N_IN*FLIT_W-1:0]   in_data,
  output logic [N_IN-1:0]          in_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [FLIT_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [N_IN-1:0]          grant,
  output logic [$clog2(N_IN)-1:0]  grant_id,
  output logic                     busy,
  output logic [ADDR_W-1:0]        out_src_addr,
  output logic [15:0]              flit_cnt,
  output logic                     timeout_err
);

  localparam int IW = $clog2(N_IN);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);

  arb_state_t        state_q;
  logic [N_IN-1:0]   grant_q;
  logic [IW-1:0]     gid_q;
  logic [IW-1:0]     ptr_q;
  logic              busy_q;
  logic              terr_q;
  logic [ADDR_W-1:0] src_q;
  logic [15:0]       cnt_q;
  logic [15:0]       idle_q;

  logic [N_IN-1:0]   pick;
  logic [IW-1:0]     pick_id;
  logic              any_req;
  logic [ADDR_W-1:0] pick_src;
  logic              req_g;
  logic              hs;
  logic              to_fire;
  logic              rel;
  logic [15:0]       cnt_d;
  logic [IW-1:0]     ptr_d;

  rr_priority_picker #(
    .N (N_IN)
  ) u_pick (
    .req_i  (in_req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_id),
    .any_o  (any_req)
  );

  // grant_q is zero outside XFER, so the mux idles at zero.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    req_g     = 1'b0;
    pick_src  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_q[i]) begin
        out_valid = in_valid[i];
        out_last  = in_last[i];
        out_data  = in_data[i*FLIT_W +: FLIT_W];
        req_g     = in_req[i];
      end
      if (pick[i]) begin
        pick_src = in_src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign in_ready = grant_q & {N_IN{out_ready}};
  assign hs       = out_valid & out_ready;

  // Tail handshake wins over abort; abort wins over timeout.
  assign to_fire = !hs && req_g && (idle_q == IDLE_MAX);
  assign rel     = (hs && out_last) || (!hs && !req_g)
                 || to_fire;

  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q
                                     : cnt_q + 16'd1;
  assign ptr_d = (gid_q == IW'(N_IN - 1)) ? '0
                                          : gid_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      terr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= XFER;
            grant_q <= pick;
            gid_q   <= pick_id;
            src_q   <= pick_src;
            cnt_q   <= '0;
            idle_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        XFER: begin
          if (hs) cnt_q <= cnt_d;
          if (rel) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            terr_q  <= to_fire;
          end else if (hs) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign grant_id     = gid_q;
  assign busy         = busy_q;
  assign out_src_addr = src_q;
  assign flit_cnt     = cnt_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_router_out_port_arbiter.sv
// Bench for router_out_port_arbiter: directed scenarios plus random
// traffic compared against a packet-level reference model.
module tb_router_out_port_arbiter;

  localparam int N  = 5;
  localparam int A  = 10;
  localparam int F  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_req, in_valid, in_last, in_ready, grant;
  logic [N*A-1:0] in_src_addr;
  logic [N*F-1:0] in_data;
  logic           out_valid, out_last, out_ready;
  logic           busy, timeout_err;
  logic [F-1:0]   out_data;
  logic [2:0]     grant_id;
  logic [A-1:0]   out_src_addr;
  logic [15:0]    flit_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: granted input (-1 = none), pointer, counters.
  int         m_g, m_ptr, m_cnt, m_idle;
  logic [A-1:0] m_src;
  logic       m_terr;

  always #5 clk = ~clk;

  router_out_port_arbiter #(
    .N_IN(N), .ADDR_W(A), .FLIT_W(F), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req), .in_src_addr(in_src_addr),
    .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last),
    .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .grant_id(grant_id), .busy(busy),
    .out_src_addr(out_src_addr), .flit_cnt(flit_cnt),
    .timeout_err(timeout_err)
  );

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_cnt = 0; m_idle = 0;
    m_src = '0; m_terr = 1'b0;
  endtask

  // Applies the packet rules for one clock edge.
  task automatic model_edge();
    bit hs, tail, stall_out;
    m_terr = 1'b0;
    if (m_g < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (in_req[j]) begin
          m_g = j;
          m_src = in_src_addr[j*A +: A];
          m_cnt = 0;
          m_idle = 0;
          break;
        end
      end
    end else begin
      hs = in_valid[m_g] && out_ready;
      if (hs && m_cnt < 65535) m_cnt++;
      tail = hs && in_last[m_g];
      stall_out = !hs && in_req[m_g] && (m_idle == TO - 1);
      if (tail || (!hs && !in_req[m_g]) || stall_out) begin
        m_terr = stall_out;
        m_ptr = (m_g + 1) % N;
        m_g = -1;
      end else if (hs) m_idle = 0;
      else m_idle++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_req = '0; in_valid = '0; in_last = '0;
    in_data = '0; in_src_addr = '0; out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    in_req = 5'b11111;
    in_valid = 5'b11111;
    rst_n = 1'b0;
    #12;
    checks++;
    if (grant !== 5'b0) begin errors++;
      $display("FAIL reset_grant: got %b want 0", grant); end
    checks++;
    if (grant_id !== 3'd0) begin errors++;
      $display("FAIL reset_gid: got %0d want 0", grant_id); end
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (out_src_addr !== 10'h0) begin errors++;
      $display("FAIL reset_src: got %h want 0", out_src_addr); end
    checks++;
    if (flit_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_cnt: got %h want 0", flit_cnt); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL reset_terr: got %b want 0", timeout_err); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 5'b0) begin errors++;
      $display("FAIL reset_link: valid %b ready %b want 0",
               out_valid, in_ready); end
    clear_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    in_src_addr[1*A +: A] = 10'h1;
    in_req = 5'b00010;
    tick();
    checks++;
    if (grant !== 5'b00010 || grant_id !== 3'd1) begin errors++;
      $display("FAIL single_grant: got %b/%0d want 00010/1",
               grant, grant_id); end
    checks++;
    if (out_src_addr !== 10'h1 || busy !== 1'b1) begin errors++;
      $display("FAIL single_src: got %h busy %b want 001 busy 1",
               out_src_addr, busy); end
    for (int f = 0; f < 3; f++) begin
      in_valid = 5'b00010;
      in_data[1*F +: F] = 32'hA000 + f;
      in_last = (f == 2) ? 5'b00010 : 5'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA000 + f
          || in_ready !== 5'b00010) begin errors++;
        $display("FAIL single_flit%0d: v %b d %h r %b", f,
                 out_valid, out_data, in_ready); end
      checks++;
      if (out_last !== (f == 2)) begin errors++;
        $display("FAIL single_last%0d: got %b", f, out_last); end
      tick();
    end
    in_req = '0;
    in_valid = 5'b11111;
    in_last = '0;
    #1;
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL single_release: grant %b busy %b want 0",
               grant, busy); end
    checks++;
    if (flit_cnt !== 16'd3 || out_src_addr !== 10'h1) begin
      errors++;
      $display("FAIL single_hold: cnt %0d src %h want 3/001",
               flit_cnt, out_src_addr); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0
        || in_ready !== 5'b0) begin errors++;
      $display("FAIL idle_link: v %b d %h r %b want zeros",
               out_valid, out_data, in_ready); end
    in_valid = '0;
    in_req = 5'b00111;
    tick();
    checks++;
    if (grant_id !== 3'd2) begin errors++;
      $display("FAIL single_ptr: got %0d want 2", grant_id); end
    in_req = '0;
    tick();
  endtask

  task automatic test_fairness();
    apply_reset();
    in_req = 5'b11111;
    in_valid = 5'b11111;
    in_last = 5'b11111;
    for (int i = 0; i < N; i++) in_data[i*F +: F] = 32'hF0 + i;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || grant_id !== 3'(n % 5)
          || grant !== 5'(1 << (n % 5))) begin errors++;
        $display("FAIL fair_grant%0d: got %b/%0d want id %0d",
                 n, grant, grant_id, n % 5); end
      checks++;
      if (out_data !== 32'hF0 + (n % 5)) begin errors++;
        $display("FAIL fair_data%0d: got %h", n, out_data); end
      tick();
      checks++;
      if (busy !== 1'b0 || grant !== 5'b0) begin errors++;
        $display("FAIL fair_gap%0d: busy %b grant %b want 0",
                 n, busy, grant); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    int g, f, c;
    bit hs;
    logic [F-1:0] sent [4];
    logic [F-1:0] got [$];
    logic [A-1:0] src;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    g = $urandom_range(0, N - 1);
    src = A'($urandom);
    for (int i = 0; i < 4; i++) sent[i] = $urandom;
    in_src_addr[g*A +: A] = src;
    in_req = 5'(1 << g);
    tick();
    checks++;
    if (grant_id !== 3'(g) || out_src_addr !== src) begin
      errors++;
      $display("FAIL bp_grant: got %0d/%h want %0d/%h",
               grant_id, out_src_addr, g, src); end
    f = 0;
    c = 0;
    while (f < 4 && c < 40) begin
      out_ready = pat[c % 4];
      in_valid = 5'(1 << g);
      in_data[g*F +: F] = sent[f];
      in_last = (f == 3) ? 5'(1 << g) : 5'b0;
      #1;
      checks++;
      if (in_ready !== (out_ready ? 5'(1 << g) : 5'b0)) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b out_ready %b",
                 c, in_ready, out_ready); end
      hs = in_ready[g] && out_valid;
      if (hs) got.push_back(out_data);
      tick();
      if (hs) f++;
      checks++;
      if (flit_cnt !== 16'(f)) begin errors++;
        $display("FAIL bp_cnt%0d: got %0d want %0d",
                 c, flit_cnt, f); end
      c++;
    end
    clear_inputs();
    checks++;
    if (c >= 40 || got.size() != 4) begin errors++;
      $display("FAIL bp_done: cycles %0d flits %0d want 4",
               c, got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== sent[i]) begin errors++;
        $display("FAIL bp_data%0d: got %h want %h",
                 i, got[i], sent[i]); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL bp_release: busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    apply_reset();
    in_src_addr[2*A +: A] = 10'h22;
    in_req = 5'b00100;
    tick();
    checks++;
    if (grant_id !== 3'd2 || out_src_addr !== 10'h22) begin
      errors++;
      $display("FAIL abort_grant: got %0d/%h want 2/022",
               grant_id, out_src_addr); end
    in_valid = 5'b00100;
    in_data[2*F +: F] = 32'hDEAD;
    tick();
    checks++;
    if (flit_cnt !== 16'd1 || busy !== 1'b1) begin errors++;
      $display("FAIL abort_flit: cnt %0d busy %b want 1/1",
               flit_cnt, busy); end
    in_valid = '0;
    in_req = 5'b10011;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 5'b0
        || timeout_err !== 1'b0) begin errors++;
      $display("FAIL abort_release: busy %b grant %b terr %b",
               busy, grant, timeout_err); end
    tick();
    checks++;
    if (grant !== 5'b10000 || grant_id !== 3'd4) begin
      errors++;
      $display("FAIL abort_next: got %b/%0d want 10000/4",
               grant, grant_id); end
    in_req = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL abort_drop: busy %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int g, cyc, pulses;
    g = $urandom_range(0, N - 1);
    in_valid = '0;
    in_req = 5'(1 << g);
    tick();
    cyc = 0;
    pulses = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (timeout_err) pulses++;
      if (!busy) break;
    end
    checks++;
    if (cyc != TO) begin errors++;
      $display("FAIL to_cycles: got %0d want %0d", cyc, TO); end
    checks++;
    if (timeout_err !== 1'b1 || pulses != 1) begin errors++;
      $display("FAIL to_pulse: terr %b pulses %0d want 1/1",
               timeout_err, pulses); end
    in_req = '0;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL to_once: terr %b busy %b want 0/0",
               timeout_err, busy); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_req = 5'b01000;
    in_valid = 5'b01000;
    in_last = 5'b01000;
    tick();
    tick();
    in_last = '0;
    tick();
    checks++;
    if (grant_id !== 3'd3) begin errors++;
      $display("FAIL ar_setup: got %0d want 3", grant_id); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0
        || in_ready !== 5'b0) begin errors++;
      $display("FAIL ar_now: grant %b busy %b ready %b",
               grant, busy, in_ready); end
    checks++;
    if (out_valid !== 1'b0 || flit_cnt !== 16'h0) begin
      errors++;
      $display("FAIL ar_link: valid %b cnt %0d want 0",
               out_valid, flit_cnt); end
    clear_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 5'b0) begin errors++;
      $display("FAIL ar_hold: grant %b want 0", grant); end
    rst_n = 1'b1;
    model_reset();
    in_req = 5'b10100;
    tick();
    checks++;
    if (grant_id !== 3'd2 || grant !== 5'b00100) begin
      errors++;
      $display("FAIL ar_ptr: got %b/%0d want 00100/2",
               grant, grant_id); end
    in_req = '0;
    tick();
  endtask

  task automatic test_random();
    logic         ev;
    logic [F-1:0] ed;
    logic [N-1:0] er, eg;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) in_req[i] = ~in_req[i];
        in_valid[i] = ($urandom_range(0, 3) == 0);
        in_last[i]  = ($urandom_range(0, 3) == 0);
        in_data[i*F +: F] = $urandom;
        in_src_addr[i*A +: A] = A'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ev = 1'b0; ed = '0; er = '0;
      if (m_g >= 0) begin
        ev = in_valid[m_g];
        ed = in_data[m_g*F +: F];
        if (out_ready) er = 5'(1 << m_g);
      end
      checks++;
      if (out_valid !== ev || in_ready !== er
          || (ev && out_data !== ed)) begin errors++;
        $display("FAIL rnd_link%0d: v %b r %b d %h want %b %b %h",
                 c, out_valid, in_ready, out_data, ev, er, ed); end
      tick();
      eg = (m_g < 0) ? 5'b0 : 5'(1 << m_g);
      checks++;
      if (grant !== eg || busy !== (m_g >= 0)
          || grant_id !== ((m_g < 0) ? 3'd0 : 3'(m_g))) begin
        errors++;
        $display("FAIL rnd_grant%0d: %b/%0d busy %b want %b",
                 c, grant, grant_id, busy, eg); end
      checks++;
      if (out_src_addr !== m_src || flit_cnt !== 16'(m_cnt)
          || timeout_err !== m_terr) begin errors++;
        $display("FAIL rnd_state%0d: src %h cnt %0d terr %b want %h %0d %b",
                 c, out_src_addr, flit_cnt, timeout_err,
                 m_src, m_cnt, m_terr); end
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_abort();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
